// File: rtl/sersub_pkg.sv
// Shared types and constants for the serial nibble subtractor.
package sersub_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sersub_state_t;

  // Width of the nibble index register for a given slice count.
  function automatic int idx_w(input int nibbles);
    return $clog2(nibbles);
  endfunction

endpackage

// File: rtl/nibble_sub_cell.sv
// Combinational 4-bit subtractor slice: {bout, d} = a - b - bin.
module nibble_sub_cell
  import sersub_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                bin,
  output logic [NIBBLE_W-1:0] d,
  output logic                bout
);

  logic [NIBBLE_W:0] res_s;

  // A 5-bit subtract; the top bit wraps to 1 exactly when a borrow is needed.
  always_comb begin
    res_s = {1'b0, a} - {1'b0, b} - {{NIBBLE_W{1'b0}}, bin};
  end

  assign d    = res_s[NIBBLE_W-1:0];
  assign bout = res_s[NIBBLE_W];

endmodule

// File: rtl/serial_nibble_subtractor.sv
// Serial multi-word subtractor: diff = (a - b - bin) mod 2^W, one nibble per
// cycle, with valid/ready handshakes on both sides.
// Optional feature: define SERSUB_OVF_EN to add the signed-overflow output ovf.
module serial_nibble_subtractor
  import sersub_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  input  logic                       bin,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0] diff,
  output logic                       bout
`ifdef SERSUB_OVF_EN
  ,
  output logic                       ovf
`endif
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = idx_w(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  sersub_state_t       state_r;
  logic [W-1:0]        a_r;
  logic [W-1:0]        b_r;
  logic                borrow_r;
  logic [IDX_W-1:0]    idx_r;
  logic [W-1:0]        diff_r;
  logic                bout_r;
  logic [NIBBLE_W-1:0] d_s;
  logic                bnext_s;
`ifdef SERSUB_OVF_EN
  logic                ovf_r;
`endif

  // Operand registers shift right each RUN cycle, so the cell always sees nibble i.
  nibble_sub_cell u_cell (
    .a    (a_r[NIBBLE_W-1:0]),
    .b    (b_r[NIBBLE_W-1:0]),
    .bin  (borrow_r),
    .d    (d_s),
    .bout (bnext_s)
  );

  // FSM, operand/index registers and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      a_r      <= {W{1'b0}};
      b_r      <= {W{1'b0}};
      borrow_r <= 1'b0;
      idx_r    <= {IDX_W{1'b0}};
      diff_r   <= {W{1'b0}};
      bout_r   <= 1'b0;
`ifdef SERSUB_OVF_EN
      ovf_r    <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            b_r      <= b;
            borrow_r <= bin;
            idx_r    <= {IDX_W{1'b0}};
            state_r  <= RUN;
          end else begin
            state_r  <= IDLE;
          end
        end
        RUN: begin
          diff_r[int'(idx_r)*NIBBLE_W +: NIBBLE_W] <= d_s;
          borrow_r <= bnext_s;
          a_r      <= a_r >> NIBBLE_W;
          b_r      <= b_r >> NIBBLE_W;
          if (idx_r == LAST_IDX) begin
            bout_r  <= bnext_s;
`ifdef SERSUB_OVF_EN
            // On the last slice the low nibble of the shifted operands holds the MSBs.
            ovf_r   <= (a_r[NIBBLE_W-1] ^ b_r[NIBBLE_W-1]) &
                       (a_r[NIBBLE_W-1] ^ d_s[NIBBLE_W-1]);
`endif
            state_r <= DONE;
          end else begin
            idx_r   <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign diff      = diff_r;
  assign bout      = bout_r;
`ifdef SERSUB_OVF_EN
  assign ovf       = ovf_r;
`endif

endmodule

// File: tb/tb_serial_nibble_subtractor.sv
// Self-checking bench for serial_nibble_subtractor (default NIBBLES = 4).
module tb_serial_nibble_subtractor;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERSUB_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_nibble_subtractor #(.NIBBLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
`ifdef SERSUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic; ovf from the MSB rule.
  function automatic logic [W+1:0] ref_sub(input logic [W-1:0] av, input logic [W-1:0] bv,
                                           input logic biv);
    longint       ai;
    longint       bi;
    logic [W-1:0] dv;
    logic         bo;
    logic         ov;
    ai = longint'(av);
    bi = longint'(bv);
    dv = W'((ai - bi - longint'(biv)) & 64'hFFFF);
    bo = (ai < bi + longint'(biv));
    ov = (av[W-1] ^ bv[W-1]) & (av[W-1] ^ dv[W-1]);
    return {ov, bo, dv};
  endfunction

  // Called at a negedge; performs one full transaction and returns to IDLE.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic biv,
                        output logic [W-1:0] gd, output logic gb, output logic go,
                        output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    a = av; b = bv; bin = biv; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    gd = diff;
    gb = bout;
`ifdef SERSUB_OVF_EN
    go = ovf;
`else
    go = 1'b0;
`endif
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("return_to_idle", {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] gd;
    logic         gb;
    logic         go;
    int           lat;
    logic [W+1:0] r;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rbi;
    int           guard;

    vecs[0] = '{16'h0008, 16'h0003, 1'b0, 16'h0005, 1'b0, 1'b0};
    vecs[1] = '{16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b1, 1'b0};
    vecs[2] = '{16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0};
    vecs[3] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[6] = '{16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[7] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; bin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_diff", {16'd0, diff}, 32'd0);
    check("reset_bout", {31'd0, bout}, 32'd0);
`ifdef SERSUB_OVF_EN
    check("reset_ovf", {31'd0, ovf}, 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("in_ready_after_reset", {31'd0, in_ready}, 32'd1);

    // Directed vector table.
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, gd, gb, go, lat);
      check($sformatf("vec%0d_diff", i), {16'd0, gd}, {16'd0, vecs[i].d});
      check($sformatf("vec%0d_bout", i), {31'd0, gb}, {31'd0, vecs[i].bo});
`ifdef SERSUB_OVF_EN
      check($sformatf("vec%0d_ovf", i), {31'd0, go}, {31'd0, vecs[i].ov});
`endif
      check($sformatf("vec%0d_latency", i), lat, 32'd4);
    end

    // Backpressure: hold DONE for 5 cycles while offering a new operand.
    a = 16'h4321; b = 16'h1234; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("bp_reached_done", {31'd0, out_valid}, 32'd1);
    check("bp_diff", {16'd0, diff}, 32'h30ED);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = 16'hFFFF; b = 16'h0000; bin = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      check("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_hold_diff", {16'd0, diff}, 32'h30ED);
      check("bp_hold_bout", {31'd0, bout}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_idle", {30'd0, out_valid, in_ready}, 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("bp_no_ghost_op", {30'd0, out_valid, in_ready}, 32'd1);

    // Reset during RUN nibble 2 aborts the operation.
    a = 16'hABCD; b = 16'h1111; bin = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_diff", {16'd0, diff}, 32'd0);
    check("midrst_bout", {31'd0, bout}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    run_op(16'h00FF, 16'h000F, 1'b0, gd, gb, go, lat);
    check("post_rst_diff", {16'd0, gd}, 32'h00F0);
    check("post_rst_bout", {31'd0, gb}, 32'd0);
    check("post_rst_latency", lat, 32'd4);

    // Random operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      ra  = W'($urandom);
      rb  = (i % 4 == 0) ? ra : W'($urandom);
      rbi = 1'($urandom);
      r   = ref_sub(ra, rb, rbi);
      run_op(ra, rb, rbi, gd, gb, go, lat);
      check("rand_diff", {16'd0, gd}, {16'd0, r[W-1:0]});
      check("rand_bout", {31'd0, gb}, {31'd0, r[W]});
`ifdef SERSUB_OVF_EN
      check("rand_ovf", {31'd0, go}, {31'd0, r[W+1]});
`endif
      check("rand_latency", lat, 32'd4);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
